bitty_exec_ctrl: RTL and testbench
==================================

# bitty_exec_ctrl

Execution controller for the bitty core. Sequences one instruction at a time through fetch (instruction-memory latency), issue (start pulse to bitty), execute (wait for done) and PC update, with free-run, single-step and breakpoint control. Sits between the top-level run/step inputs and the bitty, pc and memory instances; drives bitty's `run` and the pc's `en_pc`.

## Interface
Parameters:
- `ADDR_W`, 8, PC/instruction-memory address width
- `MEM_LAT`, 1, cycles from a new PC value to valid instruction at memory output (≥1)
- `CNT_W`, 16, retired-instruction counter width

Ports:
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high reset
- `run`  in  1  level; free-run request, started on rising edge
- `step`  in  1  single-cycle pulse; execute exactly one instruction
- `bp_en`  in  1  breakpoint enable
- `bp_addr`  in  ADDR_W  breakpoint PC
- `pc_addr`  in  ADDR_W  current PC from the pc register
- `cpu_done`  in  1  bitty done
- `cpu_start`  out  1  one-cycle start pulse to bitty `run`
- `pc_en`  out  1  one-cycle PC advance pulse to pc `en_pc`
- `busy`  out  1  high in every state except IDLE
- `halted`  out  1  high in IDLE
- `bp_hit`  out  1  sticky; set when a breakpoint stops execution
- `instr_count`  out  CNT_W  retired instructions, wraps modulo 2^CNT_W

## Operation
- Registered outputs, all decoded from state except counters/flags. Reset values: state=IDLE, `cpu_start`=0, `pc_en`=0, `busy`=0, `halted`=1, `bp_hit`=0, `instr_count`=0; internal `run_q`=0, fetch counter=0.
- States: IDLE, FETCH, ISSUE, EXEC, UPDATE, NEXT.
- IDLE: rising edge of `run` (`run & ~run_q`) → FETCH (free-run mode); else `step` → FETCH (step mode). Both in same cycle → free-run. Breakpoint not checked on exit from IDLE (allows resume from a breakpoint PC). Leaving IDLE clears `bp_hit`.
- FETCH: held exactly MEM_LAT cycles (internal down-counter), then → ISSUE.
- ISSUE: `cpu_start`=1 for this single cycle; → EXEC.
- EXEC: wait; `cpu_done`=1 → UPDATE. `cpu_done` in any other state is ignored.
- UPDATE: `pc_en`=1 for this single cycle; `instr_count` += 1 (wraps); → NEXT.
- NEXT (new PC now visible on `pc_addr`): step mode → IDLE; free-run with `run`=0 → IDLE; free-run with `bp_en` and `pc_addr`==`bp_addr` → IDLE, `bp_hit`←1; otherwise → FETCH.
- `run` dropping mid-instruction does not abort; current instruction retires, then IDLE at NEXT.
- `step` outside IDLE ignored; `run` held high after a breakpoint does not restart — a fresh rising edge is required.
- `run_q` samples `run` every cycle.

## Timing
- Per instruction: MEM_LAT (FETCH) + 1 (ISSUE) + N (EXEC, N≥1 including the `cpu_done` cycle) + 1 (UPDATE) + 1 (NEXT) cycles.
- Back-to-back `cpu_start` pulses in free-run spaced MEM_LAT+3+N cycles.
- `cpu_start` and `pc_en` never high together; each exactly one cycle per instruction.
- `reset` asserted in any state: immediately (asynchronously) IDLE with reset values; any in-flight instruction abandoned, no `pc_en`, no count.

## Test plan
- Reset: assert `reset` mid-run → same cycle `halted`=1, `busy`=0, `cpu_start`=0, `pc_en`=0, `instr_count`=0, `bp_hit`=0.
- Single step (MEM_LAT=2, bitty model N=3): pulse `step` at PC 0 → `cpu_start` 3 cycles later, `pc_en` 4 cycles after that, `halted` back after 8 total cycles, `instr_count`=1, PC=1.
- Free run: raise and hold `run`, sequential PC from 0, N=3 → `cpu_start` every 8 cycles; after 5 instructions `instr_count`=5; drop `run` during 5th EXEC → 5th retires, IDLE, `instr_count`=5.
- Breakpoint: `bp_en`=1, `bp_addr`=3, run from PC 0 → halts with PC=3, `bp_hit`=1, `instr_count`=3, no `cpu_start` for PC 3; toggle `run` low→high → PC 3 executes, `bp_hit` clears, execution continues.
- Ignored inputs: spurious `cpu_done` in IDLE/FETCH and `step` during EXEC → no state change, no extra `pc_en`, count unchanged; `run` and `step` same cycle → free-run.
- Wrap: CNT_W=4, run 17 instructions → `instr_count`=1.

Source files
------------

// File: rtl/bitty_exec_ctrl.sv
// bitty_exec_ctrl: sequences one instruction at a time through fetch,
// issue, execute and PC update for the bitty core. It supports free-run,
// single-step and PC breakpoint control. All outputs are registered.
module bitty_exec_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              step,
  input  logic              bp_en,
  input  logic [ADDR_W-1:0] bp_addr,
  input  logic [ADDR_W-1:0] pc_addr,
  input  logic              cpu_done,
  output logic              cpu_start,
  output logic              pc_en,
  output logic              busy,
  output logic              halted,
  output logic              bp_hit,
  output logic [CNT_W-1:0]  instr_count
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_ISSUE  = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_UPDATE = 3'd4;
  localparam logic [2:0] S_NEXT   = 3'd5;

  // The fetch counter counts down from MEM_LAT-1 to 0, so FETCH lasts MEM_LAT cycles.
  localparam int              FC_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [FC_W-1:0] FC_LOAD = FC_W'(MEM_LAT - 1);

  logic [2:0]       state_q, state_d;
  logic [FC_W-1:0]  fcnt_q, fcnt_d;
  logic             free_q, free_d;
  logic             run_q;
  logic             bp_hit_q, bp_hit_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cpu_start_q, pc_en_q, busy_q, halted_q;

  // Next-state logic. Breakpoints are only checked at NEXT, so execution can resume from a breakpoint PC.
  always_comb begin
    state_d  = state_q;
    fcnt_d   = fcnt_q;
    free_d   = free_q;
    bp_hit_d = bp_hit_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (run && !run_q) begin
          state_d  = S_FETCH;
          free_d   = 1'b1;
          fcnt_d   = FC_LOAD;
          bp_hit_d = 1'b0;
        end else if (step) begin
          state_d  = S_FETCH;
          free_d   = 1'b0;
          fcnt_d   = FC_LOAD;
          bp_hit_d = 1'b0;
        end
      end
      S_FETCH: begin
        if (fcnt_q == '0) state_d = S_ISSUE;
        else              fcnt_d  = fcnt_q - FC_W'(1);
      end
      S_ISSUE: state_d = S_EXEC;
      S_EXEC: begin
        if (cpu_done) state_d = S_UPDATE;
      end
      S_UPDATE: begin
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = S_NEXT;
      end
      S_NEXT: begin
        if (!free_q || !run) begin
          state_d = S_IDLE;
        end else if (bp_en && (pc_addr == bp_addr)) begin
          state_d  = S_IDLE;
          bp_hit_d = 1'b1;
        end else begin
          state_d = S_FETCH;
          fcnt_d  = FC_LOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counters and registered outputs; outputs decode the next state so they align with state_q.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      fcnt_q      <= '0;
      free_q      <= 1'b0;
      run_q       <= 1'b0;
      bp_hit_q    <= 1'b0;
      cnt_q       <= '0;
      cpu_start_q <= 1'b0;
      pc_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      halted_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      free_q      <= free_d;
      run_q       <= run;
      bp_hit_q    <= bp_hit_d;
      cnt_q       <= cnt_d;
      cpu_start_q <= (state_d == S_ISSUE);
      pc_en_q     <= (state_d == S_UPDATE);
      busy_q      <= (state_d != S_IDLE);
      halted_q    <= (state_d == S_IDLE);
    end
  end

  assign cpu_start   = cpu_start_q;
  assign pc_en       = pc_en_q;
  assign busy        = busy_q;
  assign halted      = halted_q;
  assign bp_hit      = bp_hit_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_bitty_exec_ctrl.sv
// Directed bench for bitty_exec_ctrl with a PC register model and a bitty
// model that raises done three cycles after each start (N=3). MEM_LAT=2, CNT_W=4.
module tb_bitty_exec_ctrl;
  localparam int ADDR_W = 8;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              reset, run, step, bp_en, cpu_done, done_force;
  logic [ADDR_W-1:0] bp_addr, pc_m;
  logic              cpu_start, pc_en, busy, halted, bp_hit;
  logic [CNT_W-1:0]  instr_count;
  int                dcnt;
  int                st_cnt = 0, pe_cnt = 0;
  int                errs = 0, checks = 0;

  bitty_exec_ctrl #(.ADDR_W(ADDR_W), .MEM_LAT(2), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .run(run), .step(step), .bp_en(bp_en),
    .bp_addr(bp_addr), .pc_addr(pc_m), .cpu_done(cpu_done),
    .cpu_start(cpu_start), .pc_en(pc_en), .busy(busy), .halted(halted),
    .bp_hit(bp_hit), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // PC register model
  always @(posedge clk or posedge reset) begin
    if (reset) pc_m <= '0;
    else if (pc_en) pc_m <= pc_m + 8'd1;
  end

  // bitty model: done in the third cycle after the start pulse
  always @(posedge clk or posedge reset) begin
    if (reset) dcnt <= 0;
    else if (cpu_start) dcnt <= 3;
    else if (dcnt != 0) dcnt <= dcnt - 1;
  end
  assign cpu_done = (dcnt == 1) || done_force;

  // pulse counters
  always @(posedge clk) begin
    if (cpu_start) st_cnt <= st_cnt + 1;
    if (pc_en) pe_cnt <= pe_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sigsel(input int sel);
    case (sel)
      0:       return cpu_start;
      1:       return pc_en;
      default: return halted;
    endcase
  endfunction

  // ticks until the selected output is high; n=200 means timeout
  task automatic wait_for(input int sel, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!sigsel(sel) && n < 200);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1; run = 1'b0; step = 1'b0;
    #1;
    check({tag, "_halted"}, halted, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_start"}, cpu_start, 0);
    check({tag, "_pc_en"}, pc_en, 0);
    check({tag, "_count"}, instr_count, 0);
    check({tag, "_bp_hit"}, bp_hit, 0);
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int n, s0, p0;
    logic [CNT_W-1:0]  c0;
    logic [ADDR_W-1:0] a0;
    reset = 1'b1; run = 1'b0; step = 1'b0; bp_en = 1'b0; bp_addr = 8'd3; done_force = 1'b0;
    tick();
    do_reset("rst0");

    // single step from PC 0
    step = 1'b1; tick(); step = 1'b0;
    check("step_busy", busy, 1);
    wait_for(0, n); check("step_start_lat", n, 2);
    wait_for(1, n); check("step_pc_en_lat", n, 4);
    tick(); check("step_pc_en_single", pc_en, 0);
    check("step_count", instr_count, 1);
    wait_for(2, n); check("step_halt_lat", n, 1);
    check("step_pc", pc_m, 1);

    // free run from PC 0, drop run during 5th EXEC
    do_reset("rst1");
    run = 1'b1;
    wait_for(0, n); check("fr_first_start", n, 3);
    for (int i = 0; i < 3; i++) begin
      wait_for(0, n); check("fr_start_spacing", n, 8);
    end
    check("fr_count3", instr_count, 3);
    wait_for(0, n); check("fr_start5", n, 8);
    check("fr_pc4", pc_m, 4);
    tick(); run = 1'b0;
    wait_for(1, n); check("fr_retire5", n, 3);
    wait_for(2, n); check("fr_idle", n, 2);
    check("fr_count5", instr_count, 5);
    check("fr_pc5", pc_m, 5);
    s0 = st_cnt;
    repeat (10) tick();
    check("fr_stays_idle", st_cnt - s0, 0);

    // reset asserted during EXEC
    run = 1'b1;
    wait_for(0, n); check("mr_start", n, 3);
    tick();
    p0 = pe_cnt;
    do_reset("rst_mid");
    repeat (6) tick();
    check("mr_no_pc_en", pe_cnt - p0, 0);
    check("mr_count", instr_count, 0);
    check("mr_halted", halted, 1);

    // breakpoint at PC 3
    bp_en = 1'b1; bp_addr = 8'd3;
    s0 = st_cnt;
    run = 1'b1;
    wait_for(2, n); check("bp_halt_lat", n, 25);
    check("bp_pc", pc_m, 3);
    check("bp_hit", bp_hit, 1);
    check("bp_count", instr_count, 3);
    check("bp_starts", st_cnt - s0, 3);
    s0 = st_cnt;
    repeat (5) tick();
    check("bp_held_run_no_restart", st_cnt - s0, 0);
    check("bp_held_halted", halted, 1);
    run = 1'b0; tick();
    run = 1'b1; tick();
    check("bp_resume_busy", busy, 1);
    check("bp_cleared", bp_hit, 0);
    wait_for(0, n); check("bp_resume_start", n, 2);
    wait_for(1, n); check("bp_resume_pc_en", n, 4);
    tick(); check("bp_pc_past", pc_m, 4);
    wait_for(0, n); check("bp_continue", n, 3);
    run = 1'b0;
    wait_for(2, n); check("bp_stop", n, 6);
    check("bp_pc5", pc_m, 5);
    bp_en = 1'b0;

    // spurious done in IDLE
    p0 = pe_cnt; c0 = instr_count; a0 = pc_m;
    done_force = 1'b1; tick(); tick(); done_force = 1'b0;
    check("ign_idle_halted", halted, 1);
    check("ign_idle_pc_en", pe_cnt - p0, 0);
    check("ign_idle_count", instr_count, c0);

    // spurious done in FETCH, step during EXEC
    step = 1'b1; tick(); step = 1'b0;
    done_force = 1'b1; tick(); done_force = 1'b0;
    check("ign_fetch_no_start", cpu_start, 0);
    check("ign_fetch_busy", busy, 1);
    tick(); check("ign_fetch_start", cpu_start, 1);
    tick();
    step = 1'b1; tick(); step = 1'b0;
    wait_for(1, n); check("ign_exec_pc_en", n, 2);
    wait_for(2, n); check("ign_exec_halt", n, 2);
    repeat (3) tick();
    check("ign_exec_still_idle", halted, 1);
    check("ign_pc", pc_m, a0 + 8'd1);
    check("ign_count", instr_count, c0 + 4'd1);
    check("ign_one_pc_en", pe_cnt - p0, 1);

    // run and step in the same cycle select free-run
    run = 1'b1; step = 1'b1; tick(); step = 1'b0;
    wait_for(0, n); check("rs_start", n, 2);
    wait_for(0, n); check("rs_second_start", n, 8);
    run = 1'b0;
    wait_for(2, n); check("rs_stop", n, 6);
    check("rs_count", instr_count, c0 + 4'd3);

    // counter wrap with CNT_W=4
    do_reset("rst_wrap");
    run = 1'b1;
    for (int i = 0; i < 16; i++) wait_for(1, n);
    tick(); check("wrap_16", instr_count, 0);
    wait_for(1, n); check("wrap_17_lat", n, 7);
    run = 1'b0;
    wait_for(2, n); check("wrap_idle", n, 2);
    check("wrap_count", instr_count, 1);
    check("wrap_pc", pc_m, 17);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
